// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill controller.
package cache_pkg;

  // Words per cache block (16-byte block of 16-bit words).
  localparam int unsigned WORDS_PER_BLOCK = 8;
  // Bits needed to index a word within a block.
  localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
  // Byte-offset bits within a block (2-byte words).
  localparam int unsigned BLOCK_OFFSET_W  = WORD_IDX_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/fill_counter.sv
// Small up-counter with synchronous clear and enable; clear wins over enable.
module fill_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear, increment or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: issues one read per word of the missing block,
// counts returning words into the data array and writes the tag on the last one.
// Optional feature macro: CACHE_FILL_PERF_CNT_EN adds a saturating 16-bit miss counter.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               mem_read_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               write_tag_array
`ifdef CACHE_FILL_PERF_CNT_EN
  ,
  output logic [15:0]                        miss_count
`endif
);

  localparam int unsigned IdxW = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned CntW = IdxW + 1;
  localparam int unsigned OffW = IdxW + 1;
  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((1 << OffW) - 1);
  localparam logic [CntW-1:0]   LastIdx = CntW'(WORDS_PER_BLOCK - 1);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CntW-1:0]   issue_cnt, ret_cnt;
  logic [ADDR_W-1:0] word_off;
  logic              start, issue_en, ret_en;

  // Issue counter stops at WORDS_PER_BLOCK, i.e. when its MSB sets.
  fill_counter #(
    .Width (CntW)
  ) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (issue_en),
    .count (issue_cnt)
  );

  fill_counter #(
    .Width (CntW)
  ) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (ret_en),
    .count (ret_cnt)
  );

  assign word_off = ADDR_W'({issue_cnt[IdxW-1:0], 1'b0});

  // Next-state and output decode.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    start            = 1'b0;
    issue_en         = 1'b0;
    ret_en           = 1'b0;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    write_tag_array  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          start   = 1'b1;
          base_d  = miss_address & ~OffMask;
          state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_cnt[IdxW]) begin
          mem_read_en    = 1'b1;
          issue_en       = 1'b1;
          memory_address = base_q + word_off;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word        = ret_cnt[IdxW-1:0];
          ret_en           = 1'b1;
          if (ret_cnt == LastIdx) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and block base registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0] miss_count_q;

  // Saturating count of accepted misses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count_q <= '0;
    end else if (start && (miss_count_q != 16'hFFFF)) begin
      miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: scoreboard of expected issue addresses
// and fill indices, consumed by a negedge monitor.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b1;
  logic [15:0] miss_address = 16'h0;
  logic        memory_data_valid = 1'b1;
  logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address;
  logic [2:0]  fill_word;
`ifdef CACHE_FILL_PERF_CNT_EN
  logic [15:0] miss_count;
  int          perf_exp = 0;
`endif

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word         (fill_word),
    .write_tag_array   (write_tag_array)
`ifdef CACHE_FILL_PERF_CNT_EN
    ,
    .miss_count        (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int writes = 0;
  int tags = 0;
  int busy_cycles = 0;
  logic [15:0] exp_addr_q[$];
  logic [2:0]  exp_word_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: compares DUT activity against the scoreboard away from the clock edge.
  always @(negedge clk) begin
    logic [2:0] w;
    if (fsm_busy) busy_cycles++;
    if (mem_read_en) begin
      check_eq("issue_pending", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) check_eq("issue_addr", 32'(memory_address), 32'(exp_addr_q.pop_front()));
    end else if (fsm_busy) begin
      check_eq("idle_issue_addr", 32'(memory_address), 32'd0);
    end
    if (write_data_array) begin
      writes++;
      check_eq("write_pending", 32'(exp_word_q.size() != 0), 32'd1);
      if (exp_word_q.size() != 0) begin
        w = exp_word_q.pop_front();
        check_eq("fill_word", 32'(fill_word), 32'(w));
        check_eq("tag_on_last", 32'(write_tag_array), 32'(w == 3'd7));
      end
    end else if (write_tag_array) begin
      check_eq("tag_without_data", 32'(write_tag_array), 32'd0);
    end
    if (write_tag_array) tags++;
  end

  task automatic push_fill(input logic [15:0] addr);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      exp_addr_q.push_back(base + 16'(2 * k));
      exp_word_q.push_back(3'(k));
    end
  endtask

  task automatic note_miss();
`ifdef CACHE_FILL_PERF_CNT_EN
    if (perf_exp < 65535) perf_exp++;
`endif
  endtask

  // Gap before valid k: 1 for regular returns, else cycling 1, 3, 5.
  function automatic int gap(input int k, input int mode);
    if (mode == 0) return 1;
    case (k % 3)
      1:       return 1;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  // Called at +1 after the edge entering FILL; drives 8 valids, returns one cycle after the last.
  // miss_mode 1 toggles miss_detected with next_addr during the fill and leaves it high at the end.
  task automatic drive_returns(input int first, input int mode, input int miss_mode,
                               input logic [15:0] next_addr, output int last);
    int t = first;
    int sent = 0;
    int cyc = 0;
    last = 0;
    while (sent < 8) begin
      if (miss_mode == 1) begin
        miss_detected = (cyc % 2 == 0);
        miss_address  = next_addr;
      end
      if (cyc == t) begin
        memory_data_valid = 1'b1;
        last = cyc;
        sent++;
        t += gap(sent, mode);
        if (sent == 8 && miss_mode == 1) miss_detected = 1'b1;
      end else begin
        memory_data_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 300) begin
        check_eq("return_timeout", 32'(sent), 32'd8);
        break;
      end
    end
    memory_data_valid = 1'b0;
  endtask

  task automatic run_fill(input string name, input logic [15:0] addr, input int first,
                          input int mode);
    int last;
    push_fill(addr);
    @(posedge clk);
    #1;
    writes = 0;
    tags = 0;
    busy_cycles = 0;
    miss_detected = 1'b1;
    miss_address  = addr;
    note_miss();
    @(posedge clk);
    #1;
    miss_detected = 1'b0;
    miss_address  = ~addr;
    drive_returns(first, mode, 0, 16'h0, last);
    @(negedge clk);
    check_eq({name, "_busy_after"}, 32'(fsm_busy), 32'd0);
    check_eq({name, "_writes"}, 32'(writes), 32'd8);
    check_eq({name, "_tags"}, 32'(tags), 32'd1);
    check_eq({name, "_busy_cycles"}, 32'(busy_cycles), 32'(last + 1));
    check_eq({name, "_issues_left"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    int last;
    // Reset held with miss and valid asserted: everything stays quiet.
    @(negedge clk);
    check_eq("rst_busy", 32'(fsm_busy), 32'd0);
    check_eq("rst_rd", 32'(mem_read_en), 32'd0);
    check_eq("rst_addr", 32'(memory_address), 32'd0);
    check_eq("rst_wr", 32'(write_data_array), 32'd0);
    check_eq("rst_word", 32'(fill_word), 32'd0);
    check_eq("rst_tag", 32'(write_tag_array), 32'd0);
    @(posedge clk);
    #1;
    miss_detected = 1'b0;
    memory_data_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", 32'(fsm_busy), 32'd0);

    run_fill("basic", 16'h1236, 4, 0);
    run_fill("zero_lat", 16'h0A0C, 0, 0);
    run_fill("irreg_a", 16'h2468, 1, 1);
    run_fill("irreg_b", 16'h8ACE, 2, 1);

    // Miss while busy: toggled miss ignored, held miss starts right after busy drops.
    push_fill(16'h3004);
    push_fill(16'h5A5C);
    @(posedge clk);
    #1;
    writes = 0;
    tags = 0;
    miss_detected = 1'b1;
    miss_address  = 16'h3004;
    note_miss();
    @(posedge clk);
    #1;
    drive_returns(4, 0, 1, 16'h5A5C, last);
    @(negedge clk);
    check_eq("hold_busy_drop", 32'(fsm_busy), 32'd0);
    check_eq("hold_rd_idle", 32'(mem_read_en), 32'd0);
    note_miss();
    @(posedge clk);
    #1;
    miss_detected = 1'b0;
    @(negedge clk);
    check_eq("hold_restart", 32'(fsm_busy), 32'd1);
    @(posedge clk);
    #1;
    drive_returns(3, 0, 0, 16'h0, last);
    @(negedge clk);
    check_eq("hold_writes", 32'(writes), 32'd16);
    check_eq("hold_tags", 32'(tags), 32'd2);
    check_eq("hold_issues_left", 32'(exp_addr_q.size()), 32'd0);

`ifdef CACHE_FILL_PERF_CNT_EN
    check_eq("perf_count", 32'(miss_count), 32'(perf_exp));
`endif

    // Reset mid-fill after the third valid.
    push_fill(16'h4450);
    @(posedge clk);
    #1;
    writes = 0;
    tags = 0;
    miss_detected = 1'b1;
    miss_address  = 16'h4450;
    note_miss();
    @(posedge clk);
    #1;
    miss_detected = 1'b0;
    for (int c = 0; c < 7; c++) begin
      memory_data_valid = (c >= 4);
      @(posedge clk);
      #1;
    end
    check_eq("mid_writes", 32'(writes), 32'd3);
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_word_q.delete();
`ifdef CACHE_FILL_PERF_CNT_EN
    perf_exp = 0;
`endif
    #1;
    check_eq("mid_busy", 32'(fsm_busy), 32'd0);
    check_eq("mid_rd", 32'(mem_read_en), 32'd0);
    check_eq("mid_wr", 32'(write_data_array), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    memory_data_valid = 1'b0;
    check_eq("mid_tags", 32'(tags), 32'd0);
    check_eq("mid_writes_after", 32'(writes), 32'd3);

    run_fill("top_block", 16'hFFF8, 0, 0);

`ifdef CACHE_FILL_PERF_CNT_EN
    check_eq("perf_after_rst", 32'(miss_count), 32'(perf_exp));
    @(posedge clk);
    #1;
    dut.miss_count_q = 16'hFFFE;
    perf_exp = 65534;
    run_fill("sat_a", 16'h0100, 1, 0);
    run_fill("sat_b", 16'h0200, 1, 0);
    check_eq("perf_saturate", 32'(miss_count), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between a cache (I-cache or D-cache) and the multi-cycle, pipelined main memory that replaces the single-cycle data/instruction memories. On a cache miss it issues eight sequential word reads for the 16-byte block, counts the returning words, and steers them into the cache data array, writing the tag on the last word. The CPU pipeline stalls on `miss_detected | fsm_busy`.

## Interface
- `WORDS_PER_BLOCK`, default 8: words per cache block; power of two.
- `ADDR_W`, default 16: byte-address width.
- `clk  in  1`: system clock, all state updates on rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `miss_detected  in  1`: cache lookup missed this cycle; sampled only in IDLE.
- `miss_address  in  ADDR_W`: byte address of the missing access.
- `memory_data_valid  in  1`: main memory returns one word this cycle.
- `fsm_busy  out  1`: fill in progress.
- `mem_read_en  out  1`: issue strobe to main memory.
- `memory_address  out  ADDR_W`: byte address of the word being issued.
- `write_data_array  out  1`: write the returning word into the data array.
- `fill_word  out  log2(WORDS_PER_BLOCK)`: word index within the block for the current write.
- `write_tag_array  out  1`: write tag/valid for the block (single pulse).

## Operation
- States: IDLE, FILL. Reset -> IDLE; issue counter, return counter and block base are all 0; all outputs 0.
- IDLE: if `miss_detected`, latch base = `miss_address` with low 4 bits cleared, clear both counters, next state FILL. `memory_data_valid` in IDLE is ignored (no writes).
- FILL, issue side: while issue_cnt < 8, `mem_read_en`=1 and `memory_address` = base + 2*issue_cnt; issue_cnt increments each cycle. After 8 issues `mem_read_en`=0 and `memory_address` = 0.
- FILL, return side: each cycle with `memory_data_valid`=1, `write_data_array`=1, `fill_word`=ret_cnt, and ret_cnt increments. The block does not assume a fixed latency; it counts valids only.
- On the valid that carries ret_cnt == 7: `write_tag_array`=1 in the same cycle, and the next state is IDLE.
- `miss_detected` during FILL is ignored; a new miss is accepted only once the FSM is back in IDLE.
- Address arithmetic is modulo 2^ADDR_W. Base is block-aligned, so a fill never crosses a block boundary.
- Asynchronous reset mid-fill: immediate return to IDLE, counters cleared, and no tag write. Returns still in flight after reset are ignored because the FSM is in IDLE.

## Timing
- `fsm_busy` and `mem_read_en` are registered-state decodes. `write_data_array`, `fill_word` and `write_tag_array` are combinational from `memory_data_valid` and ret_cnt.
- With 4-cycle memory, miss at cycle 0:
  - issues at cycles 1–8, addresses base+0 … base+14;
  - valids at cycles 5–12, with tag write at cycle 12;
  - `fsm_busy` is high for cycles 1–12 and low at cycle 13;
  - a new miss can be accepted at cycle 13.
- Minimum fill length is 8 cycles, for zero-latency memory where each valid arrives in the same cycle as its issue.

## Configuration
- `CACHE_FILL_PERF_CNT_EN` defined: adds output `miss_count  out  16`.
  - Resets to 0.
  - Increments on each IDLE->FILL transition and saturates at 16'hFFFF.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `cache_pkg`: FSM state typedef (IDLE, FILL), `WORDS_PER_BLOCK`, `BLOCK_OFFSET_W` (= 4), and `WORD_IDX_W` (= 3).
- Sub-module `fill_counter`: a `WORD_IDX_W`+1-bit counter with synchronous clear and enable and asynchronous active-low reset. It is instantiated twice, for the issue counter and the return counter.

## Test plan
- Reset: assert `rst_n`=0 with `miss_detected`=1 -> all outputs 0 and the FSM stays IDLE; after release, `fsm_busy`=0.
- Basic fill: miss at 0x1236 with 4-cycle memory -> issues at 0x1230, 0x1232 … 0x123E on consecutive cycles; `fill_word` runs 0–7 on valids; `write_tag_array` is one pulse coinciding with the 8th valid.
- Irregular returns: valids spaced 1, 3 and 5 cycles apart -> exactly 8 data writes with the correct indices, then the tag write, then IDLE; no early exit.
- Miss while busy: toggle `miss_detected` during FILL -> no restart and no base change; a miss held continuously starts its next fill the cycle after `fsm_busy` falls.
- Reset mid-fill: drop `rst_n` after the 3rd valid -> IDLE immediately with no tag write; the next miss at 0xFFF8 issues 0xFFF0 … 0xFFFE with no wrap error.
- `CACHE_FILL_PERF_CNT_EN`: three fills -> `miss_count`=3; preload near saturation -> the counter holds at 0xFFFF.
